// File: rtl/display_pkg.sv
// Shared segment constants and the nibble-to-segment mapping for the hex display.
// Patterns are active-high with bit 0 = segment a through bit 6 = segment g.
package display_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex7seg_enc.sv
// Combinational hex nibble to active-high a-g segment encoder.
module hex7seg_enc
    import display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/display_hex_scan.sv
// Time-multiplexed 7-segment hex display driver with frame-aligned value updates,
// leading-zero blanking and per-digit decimal points.
module display_hex_scan
    import display_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic                  ack,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int PS_W  = $clog2(SCAN_DIV);
    localparam int VAL_W = 4 * N_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(SCAN_DIV - 1);

    logic [PS_W-1:0]     ps_q, ps_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [VAL_W-1:0]    stage_val_q, stage_val_d;
    logic [N_DIGITS-1:0] stage_dp_q, stage_dp_d;
    logic [VAL_W-1:0]    shadow_val_q, shadow_val_d;
    logic [N_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic                pending_q, pending_d;
    logic                ack_q, ack_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [N_DIGITS-1:0] an_q, an_d;

    logic                tick;
    logic                frame_end;
    logic [3:0]          nib_arr [N_DIGITS];
    logic [N_DIGITS-1:0] lz_vec;
    logic [3:0]          nib;
    logic [6:0]          seg_hex;
    logic                blank;
    logic [6:0]          seg_act;
    logic [N_DIGITS-1:0] an_act;

    // lz_vec[k] is set when nibble k and every nibble above it are zero.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign nib_arr[gi] = shadow_val_q[4*gi +: 4];
            assign lz_vec[gi]  = (shadow_val_q[VAL_W-1:4*gi] == '0);
        end
    endgenerate

    assign tick      = (ps_q == LAST_PS);
    assign frame_end = tick && (idx_q == LAST_IDX);
    assign nib       = nib_arr[idx_q];
    assign blank     = blank_lz && (idx_q != '0) && lz_vec[idx_q];

    hex7seg_enc u_enc (
        .nib_i (nib),
        .seg_o (seg_hex)
    );

    always_comb begin
        ps_d         = tick ? '0 : ps_q + PS_W'(1);
        idx_d        = idx_q;
        stage_val_d  = stage_val_q;
        stage_dp_d   = stage_dp_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;

        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end

        if (load) begin
            stage_val_d = value_i;
            stage_dp_d  = dp_i;
        end

        // A load landing exactly on the frame boundary bypasses staging.
        if (frame_end) begin
            pending_d = 1'b0;
            if (load) begin
                shadow_val_d = value_i;
                shadow_dp_d  = dp_i;
            end else if (pending_q) begin
                shadow_val_d = stage_val_q;
                shadow_dp_d  = stage_dp_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end

        ack_d = frame_end && (load || pending_q);

        // The slot after each tick is left dark to hide segment changeover ghosts.
        seg_act = blank ? SEG_OFF : seg_hex;
        an_act  = tick ? '0 : (N_DIGITS'(1) << idx_q);

        seg_d = seg_act ^ {7{ACTIVE_LOW}};
        dp_d  = shadow_dp_q[idx_q] ^ ACTIVE_LOW;
        an_d  = an_act ^ {N_DIGITS{ACTIVE_LOW}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q         <= '0;
            idx_q        <= '0;
            stage_val_q  <= '0;
            stage_dp_q   <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            ack_q        <= 1'b0;
            seg_q        <= {7{ACTIVE_LOW}};
            dp_q         <= ACTIVE_LOW;
            an_q         <= {N_DIGITS{ACTIVE_LOW}};
        end else begin
            ps_q         <= ps_d;
            idx_q        <= idx_d;
            stage_val_q  <= stage_val_d;
            stage_dp_q   <= stage_dp_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            ack_q        <= ack_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign ack = ack_q;
    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_display_hex_scan.sv
// Randomized scoreboard bench for display_hex_scan: a cycle-level reference model
// queues the expected outputs, and a monitor compares them on the falling edge.
module tb_display_hex_scan;

    parameter bit ACTIVE_LOW = 1'b0;
    localparam int N     = 4;
    localparam int SD    = 4;
    localparam int FRAME = N * SD;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   value_i = '0;
    logic [3:0]    dp_i = '0;
    logic          load = 1'b0;
    logic          blank_lz = 1'b0;
    logic          ack;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;

    display_hex_scan #(
        .N_DIGITS   (N),
        .SCAN_DIV   (SD),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value_i  (value_i),
        .dp_i     (dp_i),
        .load     (load),
        .blank_lz (blank_lz),
        .ack      (ack),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ack;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } out_t;

    out_t exp_q[$];
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   cyc_k     = 0;
    int   exp_acks  = 0;
    int   dut_acks  = 0;
    int   mon_cycle = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s cycle %0d: got %h, required %h", nm, mon_cycle, act, req);
        end
    endtask

    // Reference model: displayed value, pending load, and scan position derived from the
    // number of cycles since reset, evaluated at every rising edge.
    initial begin : model
        logic [15:0] shown, pend_v;
        logic [3:0]  shown_dp, pend_dp, nb;
        bit          pend, fe;
        int          p, dig;
        out_t        e;
        shown = '0; shown_dp = '0; pend_v = '0; pend_dp = '0; pend = 1'b0;
        forever begin
            @(posedge clk);
            e = '0;
            if (rst) begin
                shown = '0; shown_dp = '0; pend = 1'b0; cyc_k = 0;
            end else begin
                p   = cyc_k % SD;
                dig = (cyc_k / SD) % N;
                fe  = (cyc_k % FRAME) == FRAME - 1;
                nb  = 4'((shown >> (4 * dig)) & 16'hF);
                e.ack = fe && (pend || load);
                e.an  = (p == SD - 1) ? 4'b0 : 4'(1 << dig);
                e.dp  = shown_dp[dig];
                e.seg = (blank_lz && dig > 0 && (shown >> (4 * dig)) == 0) ? 7'h00 : SEG_TAB[nb];
                if (e.ack) exp_acks++;
                if (fe) begin
                    if (load) begin
                        shown = value_i; shown_dp = dp_i;
                    end else if (pend) begin
                        shown = pend_v; shown_dp = pend_dp;
                    end
                    pend = 1'b0;
                end else if (load) begin
                    pend = 1'b1; pend_v = value_i; pend_dp = dp_i;
                end
                cyc_k++;
            end
            if (ACTIVE_LOW) begin
                e.seg = ~e.seg; e.dp = ~e.dp; e.an = ~e.an;
            end
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        out_t e;
        forever begin
            @(negedge clk);
            mon_cycle++;
            if (ack === 1'b1) dut_acks++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ack", {31'b0, ack}, {31'b0, e.ack});
                check("seg", {25'b0, seg}, {25'b0, e.seg});
                check("dp",  {31'b0, dp},  {31'b0, e.dp});
                check("an",  {28'b0, an},  {28'b0, e.an});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; value_i = v; dp_i = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < FRAME; i++) begin
            if (cyc_k % FRAME == ph) break;
            @(negedge clk);
        end
    endtask

    initial begin : stimulus
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step(FRAME + 4);

        wait_phase(6);  do_load(16'h12AF, 4'b0001); step(2 * FRAME);

        wait_phase(2);  do_load(16'h1111, 4'b0000);
        step(3);        do_load(16'h2222, 4'b1000); step(2 * FRAME);

        blank_lz = 1'b1;
        wait_phase(FRAME - 1); do_load(16'h00C0, 4'b0000); step(2 * FRAME);

        wait_phase(3);  do_load(16'h0000, 4'b0100); step(2 * FRAME);

        for (int i = 0; i < 40; i++) begin
            blank_lz = 1'($urandom_range(0, 1));
            step($urandom_range(0, 20));
            do_load(16'($urandom >> (4 * $urandom_range(0, 4))), 4'($urandom));
        end
        step(2 * FRAME);

        wait_phase(5);  do_load(16'hBEEF, 4'hF);
        wait_phase(12); rst = 1'b1;
        step(2);        rst = 1'b0;
        step(2 * FRAME);

        @(negedge clk);
        check("ack_count", 32'(dut_acks), 32'(exp_acks));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
